// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the alu_ctrl sequencer and its register file.
package alu_ctrl_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 2;

  localparam logic [OPW-1:0] OP_ADD = 2'b00;
  localparam logic [OPW-1:0] OP_SUB = 2'b01;
  localparam logic [OPW-1:0] OP_AND = 2'b10;
  localparam logic [OPW-1:0] OP_NOT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADA = 3'd1,
    ST_LOADB = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  // Two's-complement overflow of s = a op b; only add/sub can overflow.
  function automatic logic signed_ovf(input logic [OPW-1:0] op, input logic [DW-1:0] a,
                                      input logic [DW-1:0] b, input logic [DW-1:0] s);
    logic v;
    v = 1'b0;
    case (op)
      OP_ADD:  v = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
      OP_SUB:  v = (a[DW-1] != b[DW-1]) && (s[DW-1] != a[DW-1]);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// NREGS x 16 register file: one synchronous write port, one combinational read port.
module alu_regfile
  import alu_ctrl_pkg::*;
#(
  parameter  int unsigned NREGS = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [NREGS];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_ctrl.sv
// Sequences register-file operands through an external 16-bit ALU and writes the result back.
// Optional ALU_CTRL_STATUS_EN adds registered n_flag / v_flag outputs.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter  int unsigned NREGS = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_op,
  input  logic [AW-1:0]  cmd_rd,
  input  logic [AW-1:0]  cmd_rn,
  input  logic [AW-1:0]  cmd_rm,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [DW-1:0]  wr_data,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_out,
  input  logic           alu_z,
  output logic           done,
  output logic [DW-1:0]  result,
  output logic           z_flag
`ifdef ALU_CTRL_STATUS_EN
  ,
  output logic           n_flag,
  output logic           v_flag
`endif
);

  state_e         r_state, w_state_nxt;
  logic           w_accept, w_ld_a, w_ld_b, w_exec, w_write, w_ext_wr;
  logic [AW-1:0]  w_rd_addr;
  logic [DW-1:0]  w_rd_data;
  logic           w_we;
  logic [AW-1:0]  w_wr_addr;
  logic [DW-1:0]  w_wr_data;

  logic [OPW-1:0] r_op;
  logic [AW-1:0]  r_rd, r_rn, r_rm;
  logic [DW-1:0]  r_a, r_b, r_c;
  logic           r_z, r_done, r_cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_exec      = 1'b0;
    w_write     = 1'b0;
    w_ext_wr    = 1'b0;
    w_rd_addr   = r_rn;
    case (r_state)
      ST_IDLE: begin
        w_ext_wr = wr_en;
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_LOADA;
        end
      end
      ST_LOADA: begin
        w_ld_a      = 1'b1;
        w_rd_addr   = r_rn;
        w_state_nxt = ST_LOADB;
      end
      ST_LOADB: begin
        w_ld_b      = 1'b1;
        w_rd_addr   = r_rm;
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        w_write     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Writeback and external loads share the single write port; they never overlap.
  assign w_we      = w_ext_wr | w_write;
  assign w_wr_addr = w_write ? r_rd : wr_addr;
  assign w_wr_data = w_write ? r_c  : wr_data;

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (w_we),
    .i_waddr (w_wr_addr),
    .i_wdata (w_wr_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // C doubles as the result register so result is valid alongside the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_rd        <= '0;
      r_rn        <= '0;
      r_rm        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_z         <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_done      <= (w_state_nxt == ST_WRITE);
      if (w_accept) begin
        r_op <= cmd_op;
        r_rd <= cmd_rd;
        r_rn <= cmd_rn;
        r_rm <= cmd_rm;
      end
      if (w_ld_a) r_a <= w_rd_data;
      if (w_ld_b) r_b <= w_rd_data;
      if (w_exec) begin
        r_c <= alu_out;
        r_z <= alu_z;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign done      = r_done;
  assign result    = r_c;
  assign z_flag    = r_z;

`ifdef ALU_CTRL_STATUS_EN
  logic r_n, r_v;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n <= 1'b0;
      r_v <= 1'b0;
    end else if (w_exec) begin
      r_n <= alu_out[DW-1];
      r_v <= signed_ovf(r_op, r_a, r_b, alu_out);
    end
  end

  assign n_flag = r_n;
  assign v_flag = r_v;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl with a behavioural ALU stub and register-file model.
// Status-flag checks are compiled in when ALU_CTRL_STATUS_EN is defined.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  localparam int unsigned NR = 8;
  localparam int unsigned AW = 3;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_rn, cmd_rm;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [15:0]   alu_a, alu_b, alu_out, result;
  logic [1:0]    alu_op;
  logic          alu_z, done, z_flag;
`ifdef ALU_CTRL_STATUS_EN
  logic          n_flag, v_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] m_regs [NR];

  alu_ctrl #(.NREGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z),
    .done(done), .result(result), .z_flag(z_flag)
`ifdef ALU_CTRL_STATUS_EN
    , .n_flag(n_flag), .v_flag(v_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU stub
  always_comb begin
    alu_out = 16'h0000;
    case (alu_op)
      2'b00:   alu_out = alu_a + alu_b;
      2'b01:   alu_out = alu_a - alu_b;
      2'b10:   alu_out = alu_a & alu_b;
      default: alu_out = ~alu_b;
    endcase
    alu_z = (alu_out == 16'h0000);
  end

  function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    int r;
    case (op)
      2'b00:   r = (int'(a) + int'(b)) % 65536;
      2'b01:   r = (int'(a) - int'(b) + 65536) % 65536;
      2'b10:   r = int'(a & b);
      default: r = 65535 - int'(b);
    endcase
    return 16'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int addr, input logic [15:0] data);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
    m_regs[addr] = data;
  endtask

  // Issues one command from IDLE and waits for done; busy-cycle writes go to wa with random data.
  task automatic run_cmd(input logic [1:0] op, input int rd, input int rn, input int rm,
                         input bit wr_same, input int wa, input logic [15:0] wd, input bit busy_wr,
                         output logic [15:0] res, output logic z, output int lat,
                         output logic [1:0] op_seen, output logic [15:0] exp);
    cmd_valid = 1'b1; cmd_op = op;
    cmd_rd = AW'(rd); cmd_rn = AW'(rn); cmd_rm = AW'(rm);
    if (wr_same) begin
      wr_en = 1'b1; wr_addr = AW'(wa); wr_data = wd;
      m_regs[wa] = wd;
    end
    exp = ref_op(op, m_regs[rn], m_regs[rm]);
    tick();
    cmd_valid = 1'b0; wr_en = 1'b0;
    cmd_op = 2'($urandom); cmd_rd = AW'($urandom); cmd_rn = AW'($urandom); cmd_rm = AW'($urandom);
    lat = 1;
    if (busy_wr) begin wr_en = 1'b1; wr_addr = AW'(wa); wr_data = 16'($urandom); end
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      if (busy_wr) wr_data = 16'($urandom);
    end
    res = result; z = z_flag; op_seen = alu_op;
    tick();
    wr_en = 1'b0;
    m_regs[rd] = exp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < int'(NR); i++) m_regs[i] = 16'h0000;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got=%h exp=0000", result); end
    n_checks++; if (z_flag !== 1'b0) begin n_fail++; $display("FAIL reset_z got=%b exp=0", z_flag); end
    n_checks++; if ({alu_a, alu_b} !== 32'h0) begin n_fail++; $display("FAIL reset_ab got=%h exp=0", {alu_a, alu_b}); end
  endtask

  task automatic test_directed();
    logic [15:0] res, exp; logic z; int lat; logic [1:0] ops;
    do_write(1, 16'h0005); do_write(2, 16'h0003);
    run_cmd(OP_ADD, 3, 1, 2, 1'b0, 0, 16'h0, 1'b0, res, z, lat, ops, exp);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency got=%0d exp=4", lat); end
    n_checks++; if (res !== 16'h0008) begin n_fail++; $display("FAIL add_result got=%h exp=0008", res); end
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL add_z got=%b exp=0", z); end
    n_checks++; if (ops !== OP_ADD) begin n_fail++; $display("FAIL add_aluop got=%b exp=00", ops); end
    run_cmd(OP_AND, 4, 3, 3, 1'b0, 0, 16'h0, 1'b0, res, z, lat, ops, exp);
    n_checks++; if (res !== 16'h0008) begin n_fail++; $display("FAIL r3_readback got=%h exp=0008", res); end
    do_write(1, 16'h0007); do_write(2, 16'h0007);
    run_cmd(OP_SUB, 0, 1, 2, 1'b0, 0, 16'h0, 1'b0, res, z, lat, ops, exp);
    n_checks++; if (res !== 16'h0000) begin n_fail++; $display("FAIL sub_zero got=%h exp=0000", res); end
    n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL sub_zero_z got=%b exp=1", z); end
    do_write(2, 16'h0001);
    run_cmd(OP_SUB, 5, 0, 2, 1'b0, 0, 16'h0, 1'b0, res, z, lat, ops, exp);
    n_checks++; if (res !== 16'hFFFF) begin n_fail++; $display("FAIL sub_wrap got=%h exp=ffff", res); end
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL sub_wrap_z got=%b exp=0", z); end
    do_write(1, 16'hFFFF); do_write(2, 16'h0001);
    run_cmd(OP_ADD, 6, 1, 2, 1'b0, 0, 16'h0, 1'b0, res, z, lat, ops, exp);
    n_checks++; if (res !== 16'h0000 || z !== 1'b1) begin n_fail++; $display("FAIL add_wrap got=%h/%b exp=0000/1", res, z); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] res, exp; logic z; int lat; logic [1:0] ops;
    int n_acc, n_done, acc0, acc1;
    do_write(2, 16'h00FF);
    n_acc = 0; n_done = 0; acc0 = -1; acc1 = -1;
    cmd_valid = 1'b1; cmd_op = OP_NOT; cmd_rd = 3'd2; cmd_rn = 3'd2; cmd_rm = 3'd2;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready === 1'b1) begin
        if (n_acc == 0) acc0 = i; else if (n_acc == 1) acc1 = i;
        n_acc++;
      end
      if (done === 1'b1) n_done++;
      tick();
    end
    cmd_valid = 1'b0;
    m_regs[2] = ref_op(OP_NOT, 16'h0, ref_op(OP_NOT, 16'h0, m_regs[2]));
    n_checks++; if (n_acc !== 2) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=2", n_acc); end
    n_checks++; if (acc0 !== 0 || acc1 !== 5) begin n_fail++; $display("FAIL b2b_cycles got=%0d,%0d exp=0,5", acc0, acc1); end
    n_checks++; if (n_done !== 2) begin n_fail++; $display("FAIL b2b_dones got=%0d exp=2", n_done); end
    run_cmd(OP_AND, 7, 2, 2, 1'b0, 0, 16'h0, 1'b0, res, z, lat, ops, exp);
    n_checks++; if (res !== 16'h00FF) begin n_fail++; $display("FAIL b2b_r2 got=%h exp=00ff", res); end
  endtask

  task automatic test_write_timing();
    logic [15:0] res, exp; logic z; int lat; logic [1:0] ops;
    run_cmd(OP_ADD, 6, 1, 1, 1'b1, 1, 16'h1234, 1'b0, res, z, lat, ops, exp);
    n_checks++; if (res !== 16'h2468) begin n_fail++; $display("FAIL same_cycle_wr got=%h exp=2468", res); end
    do_write(4, 16'h0F0F);
    run_cmd(OP_NOT, 7, 4, 3, 1'b0, 4, 16'h0, 1'b1, res, z, lat, ops, exp);
    run_cmd(OP_AND, 5, 4, 4, 1'b0, 0, 16'h0, 1'b0, res, z, lat, ops, exp);
    n_checks++; if (res !== 16'h0F0F) begin n_fail++; $display("FAIL busy_wr_ignored got=%h exp=0f0f", res); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] res, exp; logic z; int lat; logic [1:0] ops; int n_done;
    do_write(1, 16'h0011);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 3'd3; cmd_rn = 3'd1; cmd_rm = 3'd1;
    tick();
    cmd_valid = 1'b0;
    n_done = 0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < int'(NR); i++) m_regs[i] = 16'h0000;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", cmd_ready); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL midrst_result got=%h exp=0000", result); end
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL midrst_done got=%0d exp=0", n_done); end
    run_cmd(OP_ADD, 4, 3, 1, 1'b0, 0, 16'h0, 1'b0, res, z, lat, ops, exp);
    n_checks++; if (res !== 16'h0000) begin n_fail++; $display("FAIL midrst_rd got=%h exp=0000", res); end
  endtask

  task automatic test_random();
    logic [15:0] res, exp; logic z; int lat; logic [1:0] ops;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) do_write($urandom_range(0, NR - 1), 16'($urandom));
      run_cmd(2'($urandom), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
              $urandom_range(0, NR - 1), 1'($urandom), $urandom_range(0, NR - 1),
              16'($urandom), 1'($urandom), res, z, lat, ops, exp);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d exp=4", n, lat); end
      n_checks++; if (res !== exp) begin n_fail++; $display("FAIL rand_result[%0d] got=%h exp=%h", n, res, exp); end
      n_checks++; if (z !== (exp == 16'h0)) begin n_fail++; $display("FAIL rand_z[%0d] got=%b exp=%b", n, z, exp == 16'h0); end
    end
  endtask

`ifdef ALU_CTRL_STATUS_EN
  task automatic test_status();
    logic [15:0] res, exp; logic z; int lat; logic [1:0] ops;
    do_write(1, 16'h7FFF); do_write(2, 16'h0001);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 3'd3; cmd_rn = 3'd1; cmd_rm = 3'd2;
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin tick(); lat++; end
    n_checks++; if (result !== 16'h8000) begin n_fail++; $display("FAIL status_result got=%h exp=8000", result); end
    n_checks++; if (n_flag !== 1'b1 || v_flag !== 1'b1) begin n_fail++; $display("FAIL status_nv got=%b%b exp=11", n_flag, v_flag); end
    tick();
    m_regs[3] = 16'h8000;
    run_cmd(OP_AND, 4, 1, 1, 1'b0, 0, 16'h0, 1'b0, res, z, lat, ops, exp);
    n_checks++; if (n_flag !== 1'b0 || v_flag !== 1'b0) begin n_fail++; $display("FAIL status_and got=%b%b exp=00", n_flag, v_flag); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_write_timing();
    test_reset_mid();
    test_random();
`ifdef ALU_CTRL_STATUS_EN
    test_status();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
